// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle MIPS control slice: ALU codes, opcodes,
// R-type function codes and the controller state assignment.
package multicycle_ctrl_fsm_pkg;

   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_MEMADR = 4'd2,
      ST_MEMRD  = 4'd3,
      ST_MEMWB  = 4'd4,
      ST_MEMWR  = 4'd5,
      ST_RTEX   = 4'd6,
      ST_RTWB   = 4'd7,
      ST_BEQEX  = 4'd8,
      ST_ADDIEX = 4'd9,
      ST_ADDIWB = 4'd10,
      ST_JEX    = 4'd11
   } state_t;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FUNCT_ADD = 6'h20;
   localparam logic [5:0] FUNCT_SUB = 6'h22;
   localparam logic [5:0] FUNCT_AND = 6'h24;
   localparam logic [5:0] FUNCT_OR  = 6'h25;
   localparam logic [5:0] FUNCT_NOR = 6'h27;
   localparam logic [5:0] FUNCT_SLT = 6'h2A;

   // Non-R-type opcodes the controller knows how to sequence.
   function automatic logic op_supported(input logic [5:0] op);
      return (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
             (op == OP_ADDI) || (op == OP_J);
   endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_alu_decoder.sv
// R-type function field to ALU operation; funct_valid flags the supported subset.
module multicycle_ctrl_fsm_alu_decoder
   import multicycle_ctrl_fsm_pkg::*;
(
   input  logic [5:0] funct,
   output logic [3:0] alu_control,
   output logic       funct_valid
);

   always_comb begin
      alu_control = ALU_ADD;
      funct_valid = 1'b1;
      case (funct)
         FUNCT_ADD: alu_control = ALU_ADD;
         FUNCT_SUB: alu_control = ALU_SUB;
         FUNCT_AND: alu_control = ALU_AND;
         FUNCT_OR:  alu_control = ALU_OR;
         FUNCT_NOR: alu_control = ALU_NOR;
         FUNCT_SLT: alu_control = ALU_SLT;
         default:   funct_valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS controller: sequences lw/sw/R-type/beq/addi/j over 3-5 cycles
// with Moore outputs driving the shared-ALU datapath.
module multicycle_ctrl_fsm
   import multicycle_ctrl_fsm_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic [3:0] alu_control,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_src,
   output logic       pc_en,
   output logic       iord,
   output logic       ir_write,
   output logic       mem_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       instr_done,
   output logic       illegal_op,
   output logic [3:0] state
);

   state_t     state_q;
   state_t     state_d;
   logic [3:0] rt_alu;
   logic       funct_valid;
   logic       op_legal;
   logic       pc_write;
   logic       branch;

   multicycle_ctrl_fsm_alu_decoder u_alu_decoder (
      .funct       (funct),
      .alu_control (rt_alu),
      .funct_valid (funct_valid)
   );

   assign op_legal = (opcode == OP_RTYPE) ? funct_valid : op_supported(opcode);
   assign state    = state_q;

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = ST_FETCH;
      case (state_q)
         ST_FETCH:  state_d = ST_DECODE;
         ST_DECODE: begin
            if (!op_legal)                                  state_d = ST_FETCH;
            else if (opcode == OP_LW || opcode == OP_SW)    state_d = ST_MEMADR;
            else if (opcode == OP_RTYPE)                    state_d = ST_RTEX;
            else if (opcode == OP_BEQ)                      state_d = ST_BEQEX;
            else if (opcode == OP_ADDI)                     state_d = ST_ADDIEX;
            else                                            state_d = ST_JEX;
         end
         ST_MEMADR: state_d = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
         ST_MEMRD:  state_d = ST_MEMWB;
         ST_RTEX:   state_d = ST_RTWB;
         ST_ADDIEX: state_d = ST_ADDIWB;
         default:   state_d = ST_FETCH;
      endcase
   end

   always_comb begin
      alu_control = ALU_ADD;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      pc_src      = 2'b00;
      iord        = 1'b0;
      ir_write    = 1'b0;
      mem_write   = 1'b0;
      reg_write   = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
      pc_write    = 1'b0;
      branch      = 1'b0;
      case (state_q)
         ST_FETCH: begin
            ir_write  = 1'b1;
            alu_src_b = 2'b01;
            pc_write  = 1'b1;
         end
         // Branch target is precomputed here so BEQEX can redirect from ALUOut.
         ST_DECODE: begin
            alu_src_b  = 2'b11;
            illegal_op = !op_legal;
         end
         ST_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         ST_MEMRD:  iord = 1'b1;
         ST_MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         ST_MEMWR: begin
            iord       = 1'b1;
            mem_write  = 1'b1;
            instr_done = 1'b1;
         end
         ST_RTEX: begin
            alu_src_a   = 1'b1;
            alu_control = rt_alu;
         end
         ST_RTWB: begin
            reg_dst    = 1'b1;
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         ST_BEQEX: begin
            alu_src_a   = 1'b1;
            alu_control = ALU_SUB;
            pc_src      = 2'b01;
            branch      = 1'b1;
            instr_done  = 1'b1;
         end
         ST_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         ST_ADDIWB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         ST_JEX: begin
            pc_src     = 2'b10;
            pc_write   = 1'b1;
            instr_done = 1'b1;
         end
         default: ;
      endcase
      pc_en = pc_write | (branch & zero);
      // Reset must suppress strobes in the cycle it is seen, before the state register clears.
      if (reset) begin
         pc_en      = 1'b0;
         ir_write   = 1'b0;
         mem_write  = 1'b0;
         reg_write  = 1'b0;
         instr_done = 1'b0;
         illegal_op = 1'b0;
      end
   end

endmodule
